// File: rtl/demux_1in2out_16bits_pkg.sv
// Shared widths, select encoding and slot state type for the 1-to-2 demux.
package demux_1in2out_16bits_pkg;

    localparam int DEMUX_WIDTH = 16;
    localparam int DEMUX_CNT_W = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready output and an accept counter.
// Load with simultaneous drain replaces the held word; data is kept after a drain.
module demux_slot
    import demux_1in2out_16bits_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             can_accept
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
        if (load) begin
            data_d  = load_data;
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign out_valid  = (state_q == SLOT_FULL);
    assign out_data   = data_q;
    assign count      = count_q;
    assign can_accept = !out_valid || out_ready;

endmodule

// File: rtl/demux_1in2out_16bits.sv
// Registered 1-to-2 demux: steers one input word to slot A or B by select, latency 1.
// Each output has its own holding slot, so a stalled consumer only backpressures words aimed at it.
module demux_1in2out_16bits
    import demux_1in2out_16bits_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             select,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count,
    output logic             busy
);

    logic a_can_accept, b_can_accept;
    logic a_load, b_load;

    // in_ready depends only on the targeted slot, never on in_valid.
    assign in_ready = (select == SEL_B) ? b_can_accept : a_can_accept;
    assign a_load   = in_valid && in_ready && (select == SEL_A);
    assign b_load   = in_valid && in_ready && (select == SEL_B);
    assign busy     = a_valid || b_valid;

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
        .clk        (clk),
        .rst        (rst),
        .load       (a_load),
        .load_data  (in_data),
        .out_ready  (a_ready),
        .out_valid  (a_valid),
        .out_data   (a),
        .count      (a_count),
        .can_accept (a_can_accept)
    );

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
        .clk        (clk),
        .rst        (rst),
        .load       (b_load),
        .load_data  (in_data),
        .out_ready  (b_ready),
        .out_valid  (b_valid),
        .out_data   (b),
        .count      (b_count),
        .can_accept (b_can_accept)
    );

endmodule
